// File: rtl/alu_uart_host.sv
// ---------------------------------------------------------------------------
// alu_uart_host
//
// Host-side initiator for the UART ALU command protocol. Accepts one request
// {op, A, B}, sends it as a 5-byte frame through a UART transmitter byte
// interface, collects the 2-byte result (high byte first) from a UART receiver
// byte interface and presents it on a valid/ready response port.
//
// Command frame: {5'b0, op}, A[15:8], A[7:0], B[15:8], B[7:0].
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload stable until that edge.
//
// Optional feature (macro RESP_TIMEOUT_EN): each response byte must arrive
// within TIMEOUT_CYCLES clocks, otherwise the transaction completes with
// resp_result = 0 and resp_timeout = 1. Without the macro the RX states wait
// indefinitely and resp_timeout is tied low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_op, req_a, req_b payload
//   resp_valid/resp_ready    response handshake; resp_result, resp_timeout
//   tx_data, tx_start        byte and one-cycle strobe to the transmitter
//   tx_busy                  transmitter busy
//   rx_data, rx_valid        byte and one-cycle strobe from the receiver
//   stray_rx                 sticky: byte received outside the RX states
//   fsm_state                current FSM state, for observation
// ---------------------------------------------------------------------------
module alu_uart_host #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic        resp_timeout,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        stray_rx,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TX_LOAD  = 3'd1;
    localparam logic [2:0] TX_ACK   = 3'd2;
    localparam logic [2:0] TX_DRAIN = 3'd3;
    localparam logic [2:0] RX_HI    = 3'd4;
    localparam logic [2:0] RX_LO    = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [2:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  res_hi;
    logic [7:0]  cur_byte;

`ifdef RESP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`else
    // Timeout parameters have no effect in this build.
    localparam int unused_timeout_cfg = TIMEOUT_CYCLES + CNT_W;
    assign resp_timeout = 1'b0;
`endif

    assign fsm_state = state;

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = {5'b0, op_q};
            3'd1:    cur_byte = a_q[15:8];
            3'd2:    cur_byte = a_q[7:0];
            3'd3:    cur_byte = b_q[15:8];
            3'd4:    cur_byte = b_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            op_q        <= 3'd0;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            res_hi      <= 8'h00;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= 16'h0000;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            stray_rx    <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            resp_timeout <= 1'b0;
            cnt          <= '0;
`endif
        end else begin
            tx_start <= 1'b0;

            // Bytes outside the RX states are dropped; this includes a byte
            // arriving on the very edge that enters RX_HI.
            if (rx_valid && state != RX_HI && state != RX_LO) begin
                stray_rx <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        a_q       <= req_a;
                        b_q       <= req_b;
                        idx       <= 3'd0;
                        req_ready <= 1'b0;
                        state     <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        state    <= TX_ACK;
                    end
                end
                TX_ACK: begin
                    // Wait for the transmitter to acknowledge the strobe.
                    if (tx_busy) begin
                        state <= TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    if (!tx_busy) begin
                        if (idx == 3'd4) begin
                            state <= RX_HI;
`ifdef RESP_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= TX_LOAD;
                        end
                    end
                end
                RX_HI: begin
                    if (rx_valid) begin
                        res_hi <= rx_data;
                        state  <= RX_LO;
`ifdef RESP_TIMEOUT_EN
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        resp_result  <= 16'h0000;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RX_LO: begin
                    if (rx_valid) begin
                        resp_result <= {res_hi, rx_data};
                        resp_valid  <= 1'b1;
                        state       <= RESP;
`ifdef RESP_TIMEOUT_EN
                        resp_timeout <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        resp_result  <= 16'h0000;
                        resp_timeout <= 1'b1;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
